// File: rtl/serial_comparator_lsb.sv
// serial_comparator_lsb: bit-serial unsigned magnitude comparator, scans operands LSB to MSB
module serial_comparator_lsb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d, sb_q, sb_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic gt_q, gt_d, eq_q, eq_d, lt_q, lt_d;
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign a_gt_b    = gt_q;
  assign a_eq_b    = eq_q;
  assign a_lt_b    = lt_q;
  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    gt_d    = gt_q;
    eq_d    = eq_q;
    lt_d    = lt_q;
    case (state_q)
      IDLE: if (in_valid && in_ready) begin
        sa_d    = a;
        sb_d    = b;
        cnt_d   = '0;
        gt_d    = 1'b0;
        eq_d    = 1'b1;
        lt_d    = 1'b0;
        state_d = SHIFT;
      end
      SHIFT: begin
        // a differing bit seen later is more significant, so it overrides earlier verdicts
        gt_d    = (sa_q[0] != sb_q[0]) ? (sa_q[0] & ~sb_q[0]) : gt_q;
        lt_d    = (sa_q[0] != sb_q[0]) ? (~sa_q[0] & sb_q[0]) : lt_q;
        eq_d    = (sa_q[0] != sb_q[0]) ? 1'b0 : eq_q;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        cnt_d   = cnt_q + CW'(1);
        state_d = (cnt_q == CW'(WIDTH - 1)) ? DONE : SHIFT;
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      gt_q    <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      gt_q    <= gt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
    end
  end
endmodule

// File: tb/tb_serial_comparator_lsb.sv
// tb_serial_comparator_lsb: directed checks of the 8-bit comparator plus exhaustive 2-bit run
module tb_serial_comparator_lsb;
  localparam logic [2:0] GT = 3'b100, EQ = 3'b010, LT = 3'b001;
  logic clk = 0, rst = 1;
  logic in_valid = 0, out_ready = 1;
  logic [7:0] a = '0, b = '0;
  logic in_ready, out_valid, a_gt_b, a_eq_b, a_lt_b, busy;
  logic in_valid2 = 0, out_ready2 = 1;
  logic [1:0] a2 = '0, b2 = '0;
  logic in_ready2, out_valid2, gt2, eq2, lt2, busy2;
  int n_vec = 0, n_err = 0, cyc = 0;
  serial_comparator_lsb #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .a_gt_b(a_gt_b), .a_eq_b(a_eq_b),
    .a_lt_b(a_lt_b), .busy(busy)
  );
  serial_comparator_lsb #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2), .a(a2), .b(b2),
    .out_valid(out_valid2), .out_ready(out_ready2), .a_gt_b(gt2), .a_eq_b(eq2),
    .a_lt_b(lt2), .busy(busy2)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic run8(input logic [7:0] va, input logic [7:0] vb, input logic [2:0] exp, input string tag);
    int k;
    @(negedge clk);
    in_valid = 1; a = va; b = vb;
    check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 0; a = ~va; b = ~vb;
    check({tag, "_busy"}, busy, 1);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_latency"}, k, 8);
    check({tag, "_flags"}, {a_gt_b, a_eq_b, a_lt_b}, exp);
    if (out_ready) begin
      @(negedge clk);
      check({tag, "_ov_drop"}, out_valid, 0);
      check({tag, "_flags_hold"}, {a_gt_b, a_eq_b, a_lt_b}, exp);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
  initial begin
    int k, last;
    logic [2:0] e;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b000);
    rst = 0;
    #1 check("post_rst_in_ready", in_ready, 1);
    run8(8'h5A, 8'h5A, EQ, "eq5a");
    run8(8'h80, 8'h7F, GT, "msb_gt");
    run8(8'h7F, 8'h80, LT, "msb_lt");
    run8(8'h01, 8'h00, GT, "lsb_gt");
    run8(8'h00, 8'hFF, LT, "zero_lt");
    run8(8'h00, 8'h00, EQ, "zero_eq");
    out_ready = 0;
    run8(8'h33, 8'h34, LT, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = 1; a = 8'hFF; b = 8'h00;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1);
      check("bp_flags", {a_gt_b, a_eq_b, a_lt_b}, LT);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    check("bp_release_ov", out_valid, 0);
    check("bp_release_flags", {a_gt_b, a_eq_b, a_lt_b}, LT);
    check("bp_release_in_ready", in_ready, 1);
    repeat (3) @(negedge clk);
    check("bp_no_capture", busy, 0);
    @(negedge clk);
    in_valid = 1; a = 8'h03; b = 8'h01;
    @(negedge clk);
    in_valid = 0;
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    rst = 1;
    @(negedge clk);
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_flags", {a_gt_b, a_eq_b, a_lt_b}, 3'b000);
    check("abort_in_ready_rst", in_ready, 0);
    rst = 0;
    #1 check("abort_in_ready", in_ready, 1);
    run8(8'h10, 8'h20, LT, "after_abort");
    repeat (12) @(negedge clk);
    check("after_abort_idle", out_valid, 0);
    a2 = 2'd0; b2 = 2'd0; in_valid2 = 1;
    last = 0;
    for (int i = 0; i < 16; i++) begin
      logic [1:0] x, y;
      x = 2'(i >> 2);
      y = 2'(i);
      k = 0;
      do begin
        @(negedge clk);
        k++;
      end while (!out_valid2 && k < 10);
      e = {x > y, x == y, x < y};
      check($sformatf("w2_%0d_%0d", x, y), {gt2, eq2, lt2}, e);
      if (i > 0) check($sformatf("w2_period_%0d", i), cyc - last, 4);
      last = cyc;
      if (i < 15) begin
        a2 = 2'((i + 1) >> 2);
        b2 = 2'(i + 1);
      end
    end
    in_valid2 = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
